// File: rtl/irq_ctrl_apb.sv
// APB interrupt controller: pending capture (edge/level), masking, priority/threshold arbitration, claim/clear.
// Define IRQ_CTRL_APB_SYNC_EN to put a 2-flop synchroniser on every irq_trigger_i bit.
module irq_ctrl_apb #(
   parameter int NUM_IRQ = 8,
   parameter int PRIO_W  = 3
) (
   input  logic               pclk_i,
   input  logic               rst_n_i,
   input  logic               enable_i,
   input  logic               psel_i,
   input  logic               penable_i,
   input  logic               pwrite_i,
   input  logic [31:0]        paddr_i,
   input  logic [31:0]        pwdata_i,
   output logic [31:0]        prdata_o,
   output logic               pready_o,
   output logic               pslverr_o,
   input  logic [NUM_IRQ-1:0] irq_trigger_i,
   output logic               interrupt_o
);

   localparam logic [7:0] ADDR_STATUS = 8'h00;
   localparam logic [7:0] ADDR_CLEAR  = 8'h04;
   localparam logic [7:0] ADDR_MASK   = 8'h08;
   localparam logic [7:0] ADDR_THRESH = 8'h0C;
   localparam logic [7:0] ADDR_MODE   = 8'h10;
   localparam logic [7:0] ADDR_CLAIM  = 8'h14;
   localparam logic [7:0] ADDR_PRIO   = 8'h40;
   localparam logic [6:0] NUM_IRQ_L   = 7'(NUM_IRQ);

   logic [NUM_IRQ-1:0] trig;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] mode;
   logic [NUM_IRQ-1:0] hist;
   logic [NUM_IRQ-1:0] prio_ok;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] set_vec;
   logic [NUM_IRQ-1:0] clr_wr;
   logic [NUM_IRQ-1:0] clr_claim;
   logic [NUM_IRQ-1:0] pending_nxt;
   logic [PRIO_W-1:0]  thresh;
   logic [PRIO_W-1:0]  prio [NUM_IRQ];
   logic               claim_valid;
   logic [4:0]         claim_id;
   logic               win_valid;
   logic [4:0]         win_id;
   logic [PRIO_W-1:0]  win_prio;
   logic [31:0]        rd_data;
   logic [31:0]        prdata_q;
   logic               irq_q;

`ifdef IRQ_CTRL_APB_SYNC_EN
   logic [NUM_IRQ-1:0] sync_q1;
   logic [NUM_IRQ-1:0] sync_q2;

   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else if (enable_i) begin
         sync_q1 <= irq_trigger_i;
         sync_q2 <= sync_q1;
      end
   end

   assign trig = sync_q2;
`else
   assign trig = irq_trigger_i;
`endif

   // Address decode: only paddr[7:0] is significant; PRIO slots start at 0x40.
   logic [7:0] addr;
   logic [7:0] prio_off;
   logic [5:0] prio_idx;
   logic       prio_hit;
   logic       fixed_hit;
   logic       mapped;
   logic       ro_hit;
   logic       access;
   logic       wr_en;
   logic       setup_rd;
   logic       claim_rd;

   assign addr      = paddr_i[7:0];
   assign prio_off  = addr - ADDR_PRIO;
   assign prio_idx  = prio_off[7:2];
   assign prio_hit  = (addr >= ADDR_PRIO) && (addr[1:0] == 2'b00) && ({1'b0, prio_idx} < NUM_IRQ_L);
   assign fixed_hit = (addr == ADDR_STATUS) || (addr == ADDR_CLEAR) || (addr == ADDR_MASK) ||
                      (addr == ADDR_THRESH) || (addr == ADDR_MODE) || (addr == ADDR_CLAIM);
   assign mapped    = fixed_hit | prio_hit;
   assign ro_hit    = (addr == ADDR_STATUS) || (addr == ADDR_CLAIM);
   assign access    = psel_i & penable_i;
   assign setup_rd  = psel_i & ~penable_i & ~pwrite_i;
   assign pslverr_o = access & (~mapped | (pwrite_i & ro_hit));
   assign wr_en     = access & pwrite_i & mapped & ~ro_hit;
   assign claim_rd  = access & ~pwrite_i & (addr == ADDR_CLAIM) & claim_valid;
   assign pready_o  = 1'b1;
   assign prdata_o  = prdata_q;
   assign interrupt_o = irq_q;

   logic unused_bits;
   assign unused_bits = ^{paddr_i[31:8], prio_off[1:0], pwdata_i};

   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_STATUS: rd_data[NUM_IRQ-1:0] = pending;
         ADDR_MASK:   rd_data[NUM_IRQ-1:0] = mask;
         ADDR_THRESH: rd_data[PRIO_W-1:0]  = thresh;
         ADDR_MODE:   rd_data[NUM_IRQ-1:0] = mode;
         ADDR_CLAIM: begin
            rd_data[31]  = claim_valid;
            rd_data[4:0] = claim_id;
         end
         default: begin
            for (int i = 0; i < NUM_IRQ; i++) begin
               if (prio_hit && (prio_idx == 6'(i))) rd_data[PRIO_W-1:0] = prio[i];
            end
         end
      endcase
   end

   always_comb begin
      prio_ok = '0;
      for (int i = 0; i < NUM_IRQ; i++) prio_ok[i] = (prio[i] <= thresh);
   end

   assign eligible = pending & mask & prio_ok;

   // Strict '<' keeps the lowest index on equal priority.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      win_prio  = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (eligible[i] && (!win_valid || (prio[i] < win_prio))) begin
            win_valid = 1'b1;
            win_id    = 5'(i);
            win_prio  = prio[i];
         end
      end
   end

   always_comb begin
      clr_claim = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (claim_rd && (claim_id == 5'(i))) clr_claim[i] = 1'b1;
      end
   end

   assign clr_wr      = (wr_en && (addr == ADDR_CLEAR)) ? pwdata_i[NUM_IRQ-1:0] : '0;
   assign set_vec     = (mode & trig & ~hist) | (~mode & trig);
   assign pending_nxt = (pending | set_vec) & ~(clr_wr | clr_claim);

   // History tracks the input every cycle, so a MODE write always sees a fresh history.
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pending     <= '0;
         mask        <= '0;
         mode        <= '0;
         hist        <= '0;
         thresh      <= '1;
         claim_valid <= 1'b0;
         claim_id    <= '0;
         prdata_q    <= '0;
         irq_q       <= 1'b0;
         for (int i = 0; i < NUM_IRQ; i++) prio[i] <= PRIO_W'(1);
      end else if (enable_i) begin
         pending     <= pending_nxt;
         hist        <= trig;
         claim_valid <= win_valid;
         claim_id    <= win_id;
         irq_q       <= |eligible;
         if (setup_rd) prdata_q <= rd_data;
         if (wr_en && (addr == ADDR_MASK))   mask   <= pwdata_i[NUM_IRQ-1:0];
         if (wr_en && (addr == ADDR_THRESH)) thresh <= pwdata_i[PRIO_W-1:0];
         if (wr_en && (addr == ADDR_MODE))   mode   <= pwdata_i[NUM_IRQ-1:0];
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (wr_en && prio_hit && (prio_idx == 6'(i))) prio[i] <= pwdata_i[PRIO_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_irq_ctrl_apb.sv
// Bench for irq_ctrl_apb: directed APB/IRQ sequences, a cycle model checked every negedge,
// and literal expectations on key reads.
module tb_irq_ctrl_apb;

   localparam int N  = 8;
   localparam int PW = 3;

   logic          pclk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          enable_i = 1'b1;
   logic          psel_i = 1'b0;
   logic          penable_i = 1'b0;
   logic          pwrite_i = 1'b0;
   logic [31:0]   paddr_i = '0;
   logic [31:0]   pwdata_i = '0;
   logic [31:0]   prdata_o;
   logic          pready_o;
   logic          pslverr_o;
   logic [N-1:0]  irq_trigger_i = '0;
   logic          interrupt_o;

   irq_ctrl_apb #(.NUM_IRQ(N), .PRIO_W(PW)) dut (
      .pclk_i(pclk_i), .rst_n_i(rst_n_i), .enable_i(enable_i),
      .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
      .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
      .pready_o(pready_o), .pslverr_o(pslverr_o),
      .irq_trigger_i(irq_trigger_i), .interrupt_o(interrupt_o)
   );

   always #5 pclk_i = ~pclk_i;

   int n_checks = 0;
   int n_fail   = 0;
   bit running  = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_pend [N];
   bit          m_mask [N];
   bit          m_mode [N];
   bit          m_hist [N];
   int          m_prio [N];
   int          m_thresh;
   bit          m_cv;
   int          m_cid;
   bit          m_int;
   logic [31:0] m_prdata;

   function automatic bit is_mapped(input int a);
      if (a == 0 || a == 4 || a == 8 || a == 12 || a == 16 || a == 20) return 1'b1;
      return (a >= 64) && (a % 4 == 0) && ((a - 64) / 4 < N);
   endfunction

   function automatic bit exp_err();
      int a;
      a = int'(paddr_i[7:0]);
      if (!(psel_i && penable_i)) return 1'b0;
      if (!is_mapped(a)) return 1'b1;
      return pwrite_i && (a == 0 || a == 20);
   endfunction

   function automatic logic [31:0] model_read(input int a);
      logic [31:0] v;
      v = '0;
      if (!is_mapped(a)) return v;
      case (a)
         0:  for (int i = 0; i < N; i++) v[i] = m_pend[i];
         8:  for (int i = 0; i < N; i++) v[i] = m_mask[i];
         12: v = 32'(m_thresh);
         16: for (int i = 0; i < N; i++) v[i] = m_mode[i];
         20: begin
            v[31]  = m_cv;
            v[4:0] = 5'(m_cid);
         end
         4:  v = '0;
         default: v = 32'(m_prio[(a - 64) / 4]);
      endcase
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0; m_hist[i] = 0; m_prio[i] = 1;
      end
      m_thresh = (1 << PW) - 1;
      m_cv = 0; m_cid = 0; m_int = 0; m_prdata = '0;
   endtask

   task automatic model_step();
      int a, best, best_key;
      bit acc, wr_ok, clr, rise;
      a     = int'(paddr_i[7:0]);
      acc   = psel_i && penable_i;
      wr_ok = acc && pwrite_i && is_mapped(a) && a != 0 && a != 20;
      best = -1;
      best_key = 1 << 30;
      for (int i = 0; i < N; i++) begin
         if (m_pend[i] && m_mask[i] && m_prio[i] <= m_thresh && m_prio[i] * 64 + i < best_key) begin
            best = i;
            best_key = m_prio[i] * 64 + i;
         end
      end
      if (psel_i && !penable_i && !pwrite_i) m_prdata = model_read(a);
      for (int i = 0; i < N; i++) begin
         clr  = (wr_ok && a == 4 && pwdata_i[i]) ||
                (acc && !pwrite_i && a == 20 && m_cv && m_cid == i);
         rise = m_mode[i] ? (irq_trigger_i[i] && !m_hist[i]) : irq_trigger_i[i];
         m_pend[i] = !clr && (m_pend[i] || rise);
         m_hist[i] = irq_trigger_i[i];
      end
      if (wr_ok) begin
         case (a)
            8:  for (int i = 0; i < N; i++) m_mask[i] = pwdata_i[i];
            12: m_thresh = int'(pwdata_i[PW-1:0]);
            16: for (int i = 0; i < N; i++) m_mode[i] = pwdata_i[i];
            default: if (a >= 64) m_prio[(a - 64) / 4] = int'(pwdata_i[PW-1:0]);
         endcase
      end
      m_cv  = (best >= 0);
      m_cid = (best >= 0) ? best : 0;
      m_int = (best >= 0);
   endtask

   always @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) model_reset();
      else if (enable_i) model_step();
   end

   always @(negedge pclk_i) begin
      if (running) begin
         chk("cyc_interrupt", 32'(interrupt_o), 32'(m_int));
         chk("cyc_prdata", prdata_o, m_prdata);
         chk("cyc_pslverr", 32'(pslverr_o), 32'(exp_err()));
         chk("cyc_pready", 32'(pready_o), 32'd1);
      end
   end

   // ---------------- drivers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge pclk_i);
      #1;
   endtask

   task automatic apb_write_irq(input logic [7:0] a, input logic [31:0] d,
                                input logic [N-1:0] irq_acc, input logic [N-1:0] irq_after,
                                output logic e);
      @(posedge pclk_i); #1;
      psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = {24'h0, a}; pwdata_i = d;
      @(posedge pclk_i); #1;
      penable_i = 1; irq_trigger_i = irq_acc;
      @(negedge pclk_i);
      e = pslverr_o;
      @(posedge pclk_i); #1;
      psel_i = 0; penable_i = 0; pwrite_i = 0; irq_trigger_i = irq_after;
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      logic e_unused;
      apb_write_irq(a, d, irq_trigger_i, irq_trigger_i, e_unused);
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
      @(posedge pclk_i); #1;
      psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = {24'h0, a};
      @(posedge pclk_i); #1;
      penable_i = 1;
      @(negedge pclk_i);
      d = prdata_o;
      e = pslverr_o;
      @(posedge pclk_i); #1;
      psel_i = 0; penable_i = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;

      tick(3);
      rst_n_i = 1;
      tick(2);

      // reset values
      apb_read(8'h0C, d, e);  chk("rst_thresh", d, 32'h7);
      apb_read(8'h40, d, e);  chk("rst_prio0", d, 32'h1);
      chk("rst_int", 32'(interrupt_o), 32'h0);
      apb_read(8'h00, d, e);  chk("rst_status", d, 32'h0);

      // edge pulse on irq[0], then clear
      apb_write(8'h08, 32'hFF);
      apb_write(8'h10, 32'h01);
      irq_trigger_i = 8'h01;
      tick(1);
      irq_trigger_i = 8'h00;
      chk("edge_int_lat0", 32'(interrupt_o), 32'h0);
      tick(1);
      chk("edge_int_lat1", 32'(interrupt_o), 32'h1);
      apb_read(8'h00, d, e);  chk("edge_status", d, 32'h01);
      apb_write(8'h04, 32'h01);
      tick(1);
      chk("clear_int", 32'(interrupt_o), 32'h0);

      // level sources with priorities, claim
      apb_write(8'h10, 32'h00);
      apb_write(8'h48, 32'h3);
      apb_write(8'h54, 32'h1);
      irq_trigger_i = 8'h24;
      tick(3);
      apb_read(8'h14, d, e);  chk("claim_first", d, 32'h8000_0005);
      irq_trigger_i = 8'h04;
      tick(1);
      apb_read(8'h14, d, e);  chk("claim_second", d, 32'h8000_0002);
      irq_trigger_i = 8'h00;
      apb_write(8'h04, 32'hFF);

      // tie at equal priority goes to lower index
      apb_write(8'h48, 32'h1);
      apb_write(8'h54, 32'h1);
      irq_trigger_i = 8'h42;
      tick(3);
      apb_read(8'h14, d, e);  chk("claim_tie", d, 32'h8000_0001);
      irq_trigger_i = 8'h00;
      apb_write(8'h04, 32'hFF);

      // threshold blocks a low-priority source
      apb_write(8'h0C, 32'h2);
      apb_write(8'h4C, 32'h4);
      irq_trigger_i = 8'h08;
      tick(3);
      apb_read(8'h00, d, e);  chk("thr_status", d, 32'h08);
      chk("thr_int", 32'(interrupt_o), 32'h0);
      apb_read(8'h14, d, e);  chk("thr_claim", d, 32'h0);
      irq_trigger_i = 8'h00;
      apb_write(8'h04, 32'hFF);
      apb_write(8'h0C, 32'h7);

      // clear vs same-cycle edge, then edge right after a clear
      apb_write(8'h10, 32'h01);
      apb_write_irq(8'h04, 32'h01, 8'h01, 8'h01, e);
      chk("clr_wr_err", 32'(e), 32'h0);
      apb_read(8'h00, d, e);  chk("clr_beats_set", d, 32'h0);
      irq_trigger_i = 8'h00;
      tick(1);
      irq_trigger_i = 8'h01;
      tick(1);
      irq_trigger_i = 8'h00;
      tick(1);
      apb_read(8'h00, d, e);  chk("edge_pending", d, 32'h01);
      apb_write_irq(8'h04, 32'h01, 8'h00, 8'h01, e);
      tick(2);
      apb_read(8'h00, d, e);  chk("edge_after_clr", d, 32'h01);
      irq_trigger_i = 8'h00;
      apb_write(8'h04, 32'hFF);

      // error responses
      apb_read(8'h2C, d, e);  chk("rd_2c_err", 32'(e), 32'h1); chk("rd_2c_data", d, 32'h0);
      apb_read(8'h60, d, e);  chk("rd_60_err", 32'(e), 32'h1); chk("rd_60_data", d, 32'h0);
      apb_read(8'h04, d, e);  chk("rd_clear_err", 32'(e), 32'h0); chk("rd_clear_data", d, 32'h0);
      apb_write_irq(8'h00, 32'hFF, 8'h00, 8'h00, e); chk("wr_status_err", 32'(e), 32'h1);
      apb_write_irq(8'h60, 32'h5, 8'h00, 8'h00, e);  chk("wr_60_err", 32'(e), 32'h1);
      apb_write_irq(8'h2C, 32'h0, 8'h00, 8'h00, e);  chk("wr_2c_err", 32'(e), 32'h1);
      apb_read(8'h00, d, e);  chk("err_status_kept", d, 32'h0);
      apb_read(8'h08, d, e);  chk("err_mask_kept", d, 32'hFF);

      // enable low freezes everything
      enable_i = 0;
      irq_trigger_i = 8'h01;
      tick(2);
      irq_trigger_i = 8'h00;
      tick(1);
      enable_i = 1;
      tick(2);
      apb_read(8'h00, d, e);  chk("enable_hold", d, 32'h0);

      // reset mid-transfer with a pending level source and enable low
      apb_write(8'h10, 32'h00);
      irq_trigger_i = 8'h10;
      tick(3);
      chk("pre_rst_int", 32'(interrupt_o), 32'h1);
      @(posedge pclk_i); #1;
      psel_i = 1; pwrite_i = 1; paddr_i = 32'h08; pwdata_i = 32'h0;
      @(posedge pclk_i); #1;
      penable_i = 1;
      #2;
      enable_i = 0;
      rst_n_i  = 0;
      #1;
      chk("async_rst_int", 32'(interrupt_o), 32'h0);
      @(posedge pclk_i); #1;
      psel_i = 0; penable_i = 0; pwrite_i = 0; irq_trigger_i = 8'h00;
      tick(1);
      rst_n_i  = 1;
      enable_i = 1;
      tick(1);
      apb_read(8'h08, d, e);  chk("post_rst_mask", d, 32'h0);
      apb_read(8'h00, d, e);  chk("post_rst_status", d, 32'h0);
      apb_read(8'h0C, d, e);  chk("post_rst_thresh", d, 32'h7);

      tick(2);
      running = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
